// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: light codes, fault codes and lamp-driver states.
// Used by both the sequencer and the lamp driver so the code stream stays consistent.
package traffic_pkg;

    localparam logic [1:0] GREEN       = 2'b00;
    localparam logic [1:0] FLASH_GREEN = 2'b01;
    localparam logic [1:0] YELLOW      = 2'b11;
    localparam logic [1:0] RED         = 2'b10;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_SEQ     = 2'b01;
    localparam logic [1:0] FLT_SHORT_Y = 2'b10;

    typedef enum logic [1:0] {
        STARTUP = 2'b00,
        RUN     = 2'b01,
        FAULT   = 2'b10
    } drv_state_t;

    // A hold, or one step forward around green -> flash -> yellow -> red -> green.
    function automatic logic legal_step(input logic [1:0] from_c, input logic [1:0] to_c);
        logic ok;
        ok = (from_c == to_c);
        case (from_c)
            GREEN:       ok = ok | (to_c == FLASH_GREEN);
            FLASH_GREEN: ok = ok | (to_c == YELLOW);
            YELLOW:      ok = ok | (to_c == RED);
            default:     ok = ok | (to_c == GREEN);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_lamp_driver_flash_gen.sv
// Blink generator: half-period counter with a phase bit, restartable so the first
// half-period after a restart is always lit.
module flash_gen #(
    parameter int FLASH_HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic restart,
    output logic phase
);

    localparam int CW = ($clog2(FLASH_HALF_PERIOD) > 1) ? $clog2(FLASH_HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    // Presents the phase that will hold after this edge, so a lamp register
    // sampling it lights in the same edge as the restart.
    assign phase = restart | (w_wrap ? ~r_phase : r_phase);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver: decodes the sequencer light code onto red/yellow/green lamps, checks the
// code stream for illegal steps and short yellow, and falls back to flashing red on a fault.
module traffic_lamp_driver
    import traffic_pkg::*;
#(
    parameter int FLASH_HALF_PERIOD = 4,
    parameter int MIN_YELLOW        = 3
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] light_code,
    input  logic       fault_clr,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

    drv_state_t    r_state;
    logic [1:0]    r_code_q;
    logic [1:0]    r_prev_q;
    logic [YW-1:0] r_ycnt;
    logic          r_skip;
    logic          r_lamp_red;
    logic          r_lamp_yellow;
    logic          r_lamp_green;
    logic          r_fault;
    logic [1:0]    r_fault_code;

    logic w_check;
    logic w_seq_bad;
    logic w_short_y;
    logic w_det;
    logic w_clear;
    logic w_to_fault;
    logic w_restart;
    logic w_phase;

    // r_skip marks the first RUN cycle after a clear, where prev_q is not a valid baseline.
    assign w_check    = (r_state == RUN) && !r_skip;
    assign w_seq_bad  = w_check && !legal_step(r_prev_q, r_code_q);
    assign w_short_y  = w_check && (r_prev_q == YELLOW) && (r_code_q == RED) && (r_ycnt < YMAX);
    assign w_det      = w_seq_bad | w_short_y;
    assign w_clear    = (r_state == FAULT) && fault_clr && (r_code_q == RED);
    assign w_to_fault = w_det || ((r_state == FAULT) && !w_clear);
    assign w_restart  = w_det ||
                        ((r_state != FAULT) && (r_code_q == FLASH_GREEN) && (r_prev_q != FLASH_GREEN));

    flash_gen #(
        .FLASH_HALF_PERIOD (FLASH_HALF_PERIOD)
    ) u_flash (
        .clk     (clk),
        .rstb    (rstb),
        .restart (w_restart),
        .phase   (w_phase)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= STARTUP;
            r_code_q      <= RED;
            r_prev_q      <= RED;
            r_ycnt        <= '0;
            r_skip        <= 1'b0;
            r_lamp_red    <= 1'b1;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FLT_NONE;
        end else begin
            r_code_q <= light_code;
            r_prev_q <= r_code_q;
            r_skip   <= 1'b0;

            if (r_code_q != YELLOW)
                r_ycnt <= '0;
            else if (r_prev_q != YELLOW)
                r_ycnt <= YW'(1);
            else if (r_ycnt != YMAX)
                r_ycnt <= r_ycnt + 1'b1;

            case (r_state)
                STARTUP: r_state <= RUN;
                RUN: begin
                    if (w_det) begin
                        r_state      <= FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_seq_bad ? FLT_SEQ : FLT_SHORT_Y;
                    end
                end
                FAULT: begin
                    if (w_clear) begin
                        r_state      <= RUN;
                        r_fault      <= 1'b0;
                        r_fault_code <= FLT_NONE;
                        r_skip       <= 1'b1;
                    end
                end
                default: r_state <= STARTUP;
            endcase

            if (w_to_fault) begin
                r_lamp_red    <= w_phase;
                r_lamp_yellow <= 1'b0;
                r_lamp_green  <= 1'b0;
            end else begin
                r_lamp_red    <= (r_code_q == RED);
                r_lamp_yellow <= (r_code_q == YELLOW);
                r_lamp_green  <= (r_code_q == GREEN) || ((r_code_q == FLASH_GREEN) && w_phase);
            end
        end
    end

    assign lamp_red    = r_lamp_red;
    assign lamp_yellow = r_lamp_yellow;
    assign lamp_green  = r_lamp_green;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;

endmodule
